// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control definitions: logic-slice op codes, controller FSM states
// and the default datapath width.
package alu_ctrl_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/logic_seq_arbiter_if.sv
// Two valid/ready request ports and one valid/ready response port of the
// bit-serial logic controller.
interface logic_seq_arbiter_if #(
  parameter int WIDTH = alu_ctrl_pkg::DEFAULT_WIDTH
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  logic             req1_ready;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_id;
  logic             rsp_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_y, rsp_id, rsp_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_y, rsp_id, rsp_zero
  );
endinterface

// File: rtl/logic_slice.sv
// Combinational 1-bit logic slice: AND / OR / XOR / NOT a selected by {s1,s0}.
// Zero latency, no flow control.
module logic_slice
  import alu_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic s0,
  input  logic s1,
  output logic y
);

  always_comb begin
    y = 1'b0;
    case ({s1, s0})
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~a;
    endcase
  end

endmodule

// File: rtl/logic_seq_arbiter.sv
// Round-robin shares one logic_slice between two requesters, runs it LSB-first.
// Response valid WIDTH+1 cycles after accept; DONE holds stable until rsp_ready.
module logic_seq_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  logic_seq_arbiter_if.slave  bus,
  output logic                busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             rr_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, y_q, y_next;
  logic [1:0]       op_q;
  logic             id_q;
  logic [WIDTH-1:0] rsp_y_q;
  logic             rsp_id_q, rsp_zero_q;
  logic             grant0, grant1, ready0, ready1, accept, last, slice_y;

  // With both valid, rr_ptr picks; a lone requester always wins.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | rr_ptr);
  assign last   = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
    case (state_q)
      IDLE: begin
        ready0 = grant0 & rst_n;
        ready1 = grant1 & rst_n;
        if (bus.req0_valid | bus.req1_valid) state_d = RUN;
      end
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept         = ready0 | ready1;
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign busy           = (state_q != IDLE);

  logic_slice u_slice (
    .a  (a_q[cnt]),
    .b  (b_q[cnt]),
    .s0 (op_q[0]),
    .s1 (op_q[1]),
    .y  (slice_y)
  );

  // Result word including the bit produced this cycle, so the last RUN cycle
  // can load the response registers directly.
  always_comb begin
    y_next      = y_q;
    y_next[cnt] = slice_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      y_q        <= '0;
      op_q       <= 2'b00;
      id_q       <= 1'b0;
      rsp_y_q    <= '0;
      rsp_id_q   <= 1'b0;
      rsp_zero_q <= 1'b0;
    end else if (accept) begin
      a_q    <= ready1 ? bus.req1_a  : bus.req0_a;
      b_q    <= ready1 ? bus.req1_b  : bus.req0_b;
      op_q   <= ready1 ? bus.req1_op : bus.req0_op;
      id_q   <= ready1;
      rr_ptr <= ~ready1;
      cnt    <= '0;
    end else if (state_q == RUN) begin
      y_q <= y_next;
      if (last) begin
        rsp_y_q    <= y_next;
        rsp_id_q   <= id_q;
        rsp_zero_q <= (y_next == '0);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/logic_seq_arbiter.md
# logic_seq_arbiter

Bit-serial controller that shares one 1-bit logic slice between two requesters in the 4-bit ALU. It arbitrates round-robin between two valid/ready request ports and latches the granted operands. It then drives the slice LSB-first for WIDTH cycles and returns the assembled word on a valid/ready response port, tagged with the requester id and a zero flag.

## Interface
Parameters:
- WIDTH, 4, operand/result width; also the number of RUN cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  2  requester 0 function, as {s1,s0}.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_a, req1_b, req1_op, req1_ready: same as the req0 ports, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_y  out  WIDTH  result word.
- rsp_id  out  1  requester that owns rsp_y.
- rsp_zero  out  1  rsp_y == 0.
- busy  out  1  state is not IDLE.

## Operation
- Op encoding {s1,s0}:
  - 00: AND
  - 01: OR
  - 10: XOR
  - 11: NOT a (b ignored)
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant when any reqN_valid is high.
  - If both are valid, grant rr_ptr.
  - reqN_ready = IDLE & grantN & rst_n (combinational); a handshake is valid & ready.
  - On a handshake: latch a, b, op and id; clear bit counter cnt; set rr_ptr = ~id; go to RUN.
- RUN:
  - Slice inputs: a = a_q[cnt], b = b_q[cnt], {s1,s0} = op_q.
  - Slice output y is written into y_q[cnt]; cnt increments.
  - After the cnt == WIDTH-1 cycle, load rsp_y/rsp_zero/rsp_id and go to DONE.
- DONE:
  - rsp_valid = 1; rsp_y, rsp_id and rsp_zero stay stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE.
- Request-port changes outside IDLE are ignored; both readies are low in RUN and DONE.
- Fairness: rr_ptr alternates on every grant, including uncontested ones. Neither requester waits more than one operation while the other is continuously valid.
- Reset values (async on rst_n low):
  - state IDLE, rr_ptr 0, cnt 0.
  - rsp_valid 0, rsp_y 0, rsp_id 0, rsp_zero 0, busy 0.
  - req0_ready/req1_ready forced 0 while rst_n is low.
- Reset mid-RUN or mid-DONE discards the in-flight operation; no response is ever produced for it.
- cnt is $clog2(WIDTH) bits wide. It never wraps in RUN, because the exit is taken at WIDTH-1.

## Timing
- Request accept cycle is C.
- RUN occupies cycles C+1 .. C+WIDTH.
- rsp_valid rises in cycle C+WIDTH+1 (WIDTH+1 cycles after the accept cycle).
- With rsp_ready held high, DONE lasts one cycle; IDLE is in C+WIDTH+2, and the next accept is possible there.
- Minimum issue period is WIDTH+2 cycles (6 at WIDTH=4).
- rsp_ready low stretches DONE indefinitely; no state or output changes during the stall.
- busy is registered-state derived: high from C+1 through the DONE handshake cycle.

## Structure
- Shared package alu_ctrl_pkg:
  - op constants OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NOTA = 2'b11.
  - FSM state typedef {IDLE, RUN, DONE}.
  - default WIDTH.
- One sub-module, logic_slice: combinational 1-bit slice with ports a, b, s0, s1, y implementing the op table. Instantiated exactly once.
- Controller contents: FSM, round-robin grant, operand/result registers, counter.

## Test plan
- Reset during RUN (rst_n low after 2 RUN cycles): all outputs go to reset values immediately; after release, no rsp_valid appears and state is IDLE.
- Single AND request: req0 a=4'b1100, b=4'b1010, op=00, rsp_ready=1 → rsp_y=4'b1000, rsp_id=0, rsp_zero=0, rsp_valid exactly 5 cycles after accept, lasting 1 cycle.
- Contention from reset: both requests valid in the same cycle.
  - req0: OR, 0011 | 0101. req1: XOR, 1111 ^ 1111.
  - Expected order: req0 served first → 0111, id 0; then req1 → 0000, id 1, rsp_zero=1.
  - A further contended pair is granted req0 first again (rr_ptr back to 0).
- Backpressure: rsp_ready low for 3 cycles in DONE → rsp_valid/rsp_y/rsp_id stable, both readies 0, busy 1; IDLE the cycle after rsp_ready rises.
- NOT a: req1 a=4'b1010, b=4'b0110, op=11 → rsp_y=4'b0101, id 1.
- Back-to-back uncontended: req1 held valid with 3 distinct ops → accepts exactly 6 cycles apart, results in order and correct.
